// File: rtl/wb_pkg.sv
// Shared types and helpers for the Wishbone bus scheduler: FSM state encoding
// and one-hot <-> binary index conversion, sized for the largest supported port count.
package wb_pkg;

  localparam int MAX_PORTS = 8;
  localparam int IDX_W_MAX = 3;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GRANT = 2'd1,
    ERR   = 2'd2,
    ABORT = 2'd3
  } state_t;

  function automatic logic [IDX_W_MAX-1:0] onehot_to_idx(input logic [MAX_PORTS-1:0] oh);
    logic [IDX_W_MAX-1:0] idx;
    idx = '0;
    for (int i = 0; i < MAX_PORTS; i++) begin
      if (oh[i]) idx = IDX_W_MAX'(i);
    end
    return idx;
  endfunction

  function automatic logic [MAX_PORTS-1:0] idx_to_onehot(input logic [IDX_W_MAX-1:0] idx);
    logic [MAX_PORTS-1:0] oh;
    oh      = '0;
    oh[idx] = 1'b1;
    return oh;
  endfunction

endpackage

// File: rtl/wb_bus_scheduler_if.sv
// Signal bundle between the N-port interconnect and the grant scheduler.
interface wb_bus_scheduler_if #(
    parameter int PORTS = 3
);
    import wb_pkg::*;

    localparam int IW = (PORTS > 1) ? $clog2(PORTS) : 1;

    // cyc_i[n] is a master's request and stays high for its whole bus cycle; the
    // request is served once grant_valid_o is high with grant_o[n] set, and the
    // slave-side transfer completes on any cycle where stb_i and ack_i are both high.
    logic [PORTS-1:0] cyc_i;
    logic             stb_i;
    logic             ack_i;
    logic [PORTS-1:0] grant_o;
    logic             grant_valid_o;
    logic [IW-1:0]    grant_idx_o;
    logic [PORTS-1:0] err_o;
    logic             busy_o;
    state_t           state_o;

    modport slave (
        input  cyc_i, stb_i, ack_i,
        output grant_o, grant_valid_o, grant_idx_o, err_o, busy_o, state_o
    );

    modport master (
        output cyc_i, stb_i, ack_i,
        input  grant_o, grant_valid_o, grant_idx_o, err_o, busy_o, state_o
    );

endinterface

// File: rtl/wb_rr_pick.sv
// Combinational winner selection: round-robin from ptr, or fixed priority from
// either end of the request vector.
module wb_rr_pick
    import wb_pkg::*;
#(
    parameter int PORTS = 3,
    localparam int IW   = (PORTS > 1) ? $clog2(PORTS) : 1
) (
    input  logic [PORTS-1:0] req,
    input  logic [IW-1:0]    ptr,
    input  logic             rr_mode,
    input  logic             lsb_high,
    output logic [PORTS-1:0] win_oh,
    output logic [IW-1:0]    win_idx
);

    logic found;
    int   c;

    // Scan order is built per mode; the first requester met in that order wins.
    always_comb begin
        found   = 1'b0;
        win_idx = '0;
        c       = 0;
        for (int i = 0; i < PORTS; i++) begin
            if (rr_mode)       c = (int'(ptr) + i) % PORTS;
            else if (lsb_high) c = i;
            else               c = PORTS - 1 - i;
            if (!found && req[c]) begin
                found   = 1'b1;
                win_idx = IW'(c);
            end
        end
    end

    assign win_oh = found ? PORTS'(idx_to_onehot(IDX_W_MAX'(win_idx))) : '0;

endmodule

// File: rtl/wb_bus_scheduler.sv
// Grant scheduler for an N-master Wishbone classic slave port with a stall
// watchdog that aborts hung transfers.
module wb_bus_scheduler
    import wb_pkg::*;
#(
    parameter int PORTS                 = 3,
    parameter int ARB_TYPE_ROUND_ROBIN  = 1,
    parameter int ARB_LSB_HIGH_PRIORITY = 1,
    parameter int TIMEOUT_CYCLES        = 256
) (
    input logic              clk,
    input logic              rst,
    wb_bus_scheduler_if.slave bus
);

    localparam int IW        = (PORTS > 1) ? $clog2(PORTS) : 1;
    localparam int CNT_WIDTH = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam int WD_LIMIT  = (TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0;
    localparam bit WD_EN     = (TIMEOUT_CYCLES > 0);

    state_t               state, state_n;
    logic [PORTS-1:0]     grant_q, grant_n;
    logic                 valid_q, valid_n;
    logic [IW-1:0]        idx_q, idx_n;
    logic [PORTS-1:0]     err_q, err_n;
    logic [IW-1:0]        rr_ptr, rr_ptr_n;
    logic [CNT_WIDTH-1:0] wd_cnt, wd_cnt_n;

    logic [PORTS-1:0]     win_oh;
    logic [IW-1:0]        win_idx;
    logic                 owner_req;
    logic                 wd_hit;

    wb_rr_pick #(.PORTS(PORTS)) u_pick (
        .req      (bus.cyc_i),
        .ptr      (rr_ptr),
        .rr_mode  (ARB_TYPE_ROUND_ROBIN != 0),
        .lsb_high (ARB_LSB_HIGH_PRIORITY != 0),
        .win_oh   (win_oh),
        .win_idx  (win_idx)
    );

    assign owner_req = |(bus.cyc_i & grant_q);
    assign wd_hit    = (wd_cnt == CNT_WIDTH'(WD_LIMIT));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            grant_q <= '0;
            valid_q <= 1'b0;
            idx_q   <= '0;
            err_q   <= '0;
            rr_ptr  <= '0;
            wd_cnt  <= '0;
        end else begin
            state   <= state_n;
            grant_q <= grant_n;
            valid_q <= valid_n;
            idx_q   <= idx_n;
            err_q   <= err_n;
            rr_ptr  <= rr_ptr_n;
            wd_cnt  <= wd_cnt_n;
        end
    end

    always_comb begin
        state_n  = state;
        grant_n  = grant_q;
        valid_n  = valid_q;
        idx_n    = idx_q;
        err_n    = '0;
        rr_ptr_n = rr_ptr;
        wd_cnt_n = wd_cnt;
        unique case (state)
            IDLE: begin
                grant_n  = '0;
                valid_n  = 1'b0;
                idx_n    = '0;
                wd_cnt_n = '0;
                if (|bus.cyc_i) begin
                    grant_n = win_oh;
                    valid_n = 1'b1;
                    idx_n   = IW'(onehot_to_idx(MAX_PORTS'(win_oh)));
                    state_n = GRANT;
                    if (ARB_TYPE_ROUND_ROBIN != 0)
                        rr_ptr_n = (win_idx == IW'(PORTS - 1)) ? '0 : win_idx + IW'(1);
                end
            end
            GRANT: begin
                if (!owner_req) begin
                    grant_n  = '0;
                    valid_n  = 1'b0;
                    idx_n    = '0;
                    wd_cnt_n = '0;
                    state_n  = IDLE;
                end else if (bus.ack_i || !bus.stb_i) begin
                    wd_cnt_n = '0;
                end else if (WD_EN && wd_hit) begin
                    // This is the last allowed stall cycle: abort the owner.
                    err_n    = grant_q;
                    valid_n  = 1'b0;
                    wd_cnt_n = '0;
                    state_n  = ERR;
                end else if (!wd_hit) begin
                    wd_cnt_n = wd_cnt + CNT_WIDTH'(1);
                end
            end
            ERR: begin
                state_n = ABORT;
            end
            ABORT: begin
                // grant_o stays up for mux steering until the aborted master lets go.
                if (!owner_req) begin
                    grant_n = '0;
                    idx_n   = '0;
                    state_n = IDLE;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    assign bus.grant_o       = grant_q;
    assign bus.grant_valid_o = valid_q;
    assign bus.grant_idx_o   = idx_q;
    assign bus.err_o         = err_q;
    assign bus.busy_o        = (state != IDLE);
    assign bus.state_o       = state;

endmodule
